// File: rtl/axis_frame_checker_pkg.sv
// Shared types and constants for the AXI4-Stream line/frame pattern checker.
// Beat layout: {frame[3:0], line[11:0], word[15:0]}.
package axis_chk_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        ALIGN = 2'd1,
        CHECK = 2'd2
    } chk_state_e;

    localparam int FRAME_MSB = 31;
    localparam int FRAME_LSB = 28;
    localparam int LINE_MSB  = 27;
    localparam int LINE_LSB  = 16;
    localparam int WORD_MSB  = 15;
    localparam int WORD_LSB  = 0;

    // Fibonacci taps 16,14,13,11 expressed as a mask over lfsr bits [15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int num_words(input int pixels_h);
        return pixels_h / 4;
    endfunction

endpackage

// File: rtl/axis_frame_checker_if.sv
// AXI4-Stream handshake/payload bundle between the pattern master and the checker.
interface axis_frame_checker_if;
    logic        tvalid;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;
    logic        tready;

    modport master (output tvalid, output tdata, output tstrb, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tstrb, input tlast, output tready);
endinterface

// File: rtl/axis_ready_throttle.sv
// TREADY generator: constant high, or a 16-bit LFSR throttle giving ~75% duty.
// TREADY is held low during reset and never looks at TVALID.
module axis_ready_throttle
    import axis_chk_pkg::*;
#(
    parameter int          READY_MODE = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic tready_o
);

    logic [15:0] lfsr_q;
    logic        en_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lfsr_q <= LFSR_SEED;
            en_q   <= 1'b0;
        end else begin
            lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
            en_q   <= 1'b1;
        end
    end

    assign tready_o = en_q & ((READY_MODE == 0) ? 1'b1 : (lfsr_q[0] | lfsr_q[1]));

endmodule

// File: rtl/axis_frame_checker.sv
// AXI4-Stream sink that locks onto line boundaries and checks each beat against
// the test-pattern formula, keeping line/frame counters and sticky error flags.
//
// state | meaning
// HUNT  | discard beats until a TLAST marks a line boundary
// ALIGN | expect word 0 of a line to seed the expected line/frame
// CHECK | locked: compare every beat and track TLAST placement
module axis_frame_checker
    import axis_chk_pkg::*;
#(
    parameter int          C_S_AXIS_TDATA_WIDTH = 32,
    parameter int          PIXELS_HORIZONTAL    = 1280,
    parameter int          PIXELS_VERTICAL      = 1024,
    parameter int          READY_MODE           = 0,
    parameter logic [15:0] LFSR_SEED            = 16'hACE1
) (
    input  logic                 S_AXIS_ACLK,
    input  logic                 S_AXIS_ARESETN,
    axis_frame_checker_if.slave  s_axis,
    input  logic                 clear_i,
    output logic                 sync_o,
    output logic [31:0]          line_count_o,
    output logic [15:0]          frame_count_o,
    output logic [15:0]          data_err_count_o,
    output logic                 err_data_o,
    output logic                 err_tlast_early_o,
    output logic                 err_tlast_missing_o,
    output logic                 err_tstrb_o,
    output logic [31:0]          first_err_data_o
);

    localparam int          DW        = C_S_AXIS_TDATA_WIDTH;
    localparam int          NW        = num_words(PIXELS_HORIZONTAL);
    localparam logic [15:0] LAST_WORD = 16'(NW - 1);
    localparam logic [11:0] LAST_LINE = 12'(PIXELS_VERTICAL - 1);

    chk_state_e    state_q, state_d;
    logic [15:0]   word_idx_q, word_idx_d;
    logic [11:0]   exp_line_q, exp_line_d;
    logic [3:0]    exp_frame_q, exp_frame_d;
    logic          sync_q;
    logic [31:0]   line_cnt_q, line_cnt_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [15:0]   err_cnt_q, err_cnt_d;
    logic          err_data_q, err_data_d;
    logic          err_early_q, err_early_d;
    logic          err_missing_q, err_missing_d;
    logic          err_tstrb_q, err_tstrb_d;
    logic [DW-1:0] first_err_q, first_err_d;
    logic [DW-1:0] exp_data;
    logic          tready;
    logic          acc;

    axis_ready_throttle #(
        .READY_MODE (READY_MODE),
        .LFSR_SEED  (LFSR_SEED)
    ) u_throttle (
        .clk_i    (S_AXIS_ACLK),
        .rst_n_i  (S_AXIS_ARESETN),
        .tready_o (tready)
    );

    assign s_axis.tready = tready;
    assign acc           = s_axis.tvalid & tready;

    always_comb begin
        state_d       = state_q;
        word_idx_d    = word_idx_q;
        exp_line_d    = exp_line_q;
        exp_frame_d   = exp_frame_q;
        line_cnt_d    = line_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        err_cnt_d     = err_cnt_q;
        err_data_d    = err_data_q;
        err_early_d   = err_early_q;
        err_missing_d = err_missing_q;
        err_tstrb_d   = err_tstrb_q;
        first_err_d   = first_err_q;
        exp_data      = {16'h0, word_idx_q} + {exp_frame_q, exp_line_q, 16'h0};

        if (acc) begin
            case (state_q)
                HUNT: begin
                    if (s_axis.tlast) state_d = ALIGN;
                end
                ALIGN: begin
                    if (s_axis.tlast) begin
                        err_early_d = 1'b1;
                    end else if (s_axis.tdata[WORD_MSB:WORD_LSB] == 16'h0) begin
                        state_d     = CHECK;
                        exp_line_d  = s_axis.tdata[LINE_MSB:LINE_LSB];
                        exp_frame_d = s_axis.tdata[FRAME_MSB:FRAME_LSB];
                        word_idx_d  = 16'd1;
                    end else begin
                        state_d = HUNT;
                    end
                end
                CHECK: begin
                    if (s_axis.tdata != exp_data) begin
                        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                        if (!err_data_q) first_err_d = s_axis.tdata;
                        err_data_d = 1'b1;
                    end
                    if (s_axis.tstrb != 4'hF) err_tstrb_d = 1'b1;

                    if (s_axis.tlast && (word_idx_q < LAST_WORD)) begin
                        err_early_d = 1'b1;
                        state_d     = ALIGN;
                    end else if (!s_axis.tlast && (word_idx_q == LAST_WORD)) begin
                        err_missing_d = 1'b1;
                        state_d       = HUNT;
                    end else if (s_axis.tlast) begin
                        line_cnt_d = line_cnt_q + 32'd1;
                        word_idx_d = 16'd0;
                        if (exp_line_q == LAST_LINE) begin
                            exp_line_d  = 12'd0;
                            exp_frame_d = exp_frame_q + 4'd1;
                            frame_cnt_d = frame_cnt_q + 16'd1;
                        end else begin
                            exp_line_d = exp_line_q + 12'd1;
                        end
                    end else begin
                        word_idx_d = word_idx_q + 16'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        // clear wins over any same-cycle update but leaves the lock untouched
        if (clear_i) begin
            line_cnt_d    = '0;
            frame_cnt_d   = '0;
            err_cnt_d     = '0;
            err_data_d    = 1'b0;
            err_early_d   = 1'b0;
            err_missing_d = 1'b0;
            err_tstrb_d   = 1'b0;
            first_err_d   = '0;
        end
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q       <= HUNT;
            word_idx_q    <= '0;
            exp_line_q    <= '0;
            exp_frame_q   <= '0;
            sync_q        <= 1'b0;
            line_cnt_q    <= '0;
            frame_cnt_q   <= '0;
            err_cnt_q     <= '0;
            err_data_q    <= 1'b0;
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;
            err_tstrb_q   <= 1'b0;
            first_err_q   <= '0;
        end else begin
            state_q       <= state_d;
            word_idx_q    <= word_idx_d;
            exp_line_q    <= exp_line_d;
            exp_frame_q   <= exp_frame_d;
            sync_q        <= (state_d == CHECK);
            line_cnt_q    <= line_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            err_cnt_q     <= err_cnt_d;
            err_data_q    <= err_data_d;
            err_early_q   <= err_early_d;
            err_missing_q <= err_missing_d;
            err_tstrb_q   <= err_tstrb_d;
            first_err_q   <= first_err_d;
        end
    end

    assign sync_o              = sync_q;
    assign line_count_o        = line_cnt_q;
    assign frame_count_o       = frame_cnt_q;
    assign data_err_count_o    = err_cnt_q;
    assign err_data_o          = err_data_q;
    assign err_tlast_early_o   = err_early_q;
    assign err_tlast_missing_o = err_missing_q;
    assign err_tstrb_o         = err_tstrb_q;
    assign first_err_data_o    = first_err_q;

endmodule
